// File: rtl/rou_axi_req_sched_if.sv
// Bundle for the ring AXI request scheduler: ring request queues, AXI4 master
// channels, the ring response stream and scheduler status.
interface rou_axi_req_sched_if #(
    parameter int DWID = 128,
    parameter int AWID = 32,
    parameter int TWID = 5
);
    logic                wr_req_valid, wr_req_ready;
    logic [AWID-1:0]     wr_req_addr;
    logic [DWID-1:0]     wr_req_data;
    logic [DWID/8-1:0]   wr_req_strb;
    logic [TWID-1:0]     wr_req_tag;
    logic                rd_req_valid, rd_req_ready;
    logic [AWID-1:0]     rd_req_addr;
    logic [TWID-1:0]     rd_req_tag;

    logic [3:0]          awid, arid, bid, rid;
    logic [AWID-1:0]     awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [2:0]          awsize, arsize;
    logic [1:0]          awburst, arburst;
    logic                awvalid, awready, arvalid, arready;
    logic [DWID-1:0]     wdata, rdata;
    logic [DWID/8-1:0]   wstrb;
    logic                wlast, wvalid, wready;
    logic [1:0]          bresp, rresp;
    logic                bvalid, bready, rlast, rvalid, rready;

    logic                rsp_valid, rsp_ready, rsp_is_read, rsp_err;
    logic [TWID-1:0]     rsp_tag;
    logic [DWID-1:0]     rsp_data;
    logic [4:0]          outstanding;
    logic                err_unexpected;

    modport master (
        input  wr_req_valid, wr_req_addr, wr_req_data, wr_req_strb, wr_req_tag,
        output wr_req_ready,
        input  rd_req_valid, rd_req_addr, rd_req_tag,
        output rd_req_ready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output rsp_valid, rsp_is_read, rsp_tag, rsp_data, rsp_err,
        input  rsp_ready,
        output outstanding, err_unexpected
    );

    modport slave (
        output wr_req_valid, wr_req_addr, wr_req_data, wr_req_strb, wr_req_tag,
        input  wr_req_ready,
        output rd_req_valid, rd_req_addr, rd_req_tag,
        input  rd_req_ready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  rsp_valid, rsp_is_read, rsp_tag, rsp_data, rsp_err,
        output rsp_ready,
        input  outstanding, err_unexpected
    );
endinterface

// File: rtl/rou_axi_req_sched.sv
// Ring AXI request scheduler: round-robin issue of single-beat AXI4 reads and
// writes from two ring queues, with an ID pool mapping B/R responses to ring tags.
module rou_axi_req_sched #(
    parameter int DWID   = 128,
    parameter int AWID   = 32,
    parameter int TWID   = 5,
    parameter int MAXOUT = 4
) (
    input logic clk,
    input logic rst,
    rou_axi_req_sched_if.master bus
);
    localparam int SW = DWID / 8;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t            state;
    logic [MAXOUT-1:0] free, free_nxt;
    logic              rr_rd;
    logic [3:0]        id_q, alloc_id, rsp_id;
    logic [AWID-1:0]   addr_q;
    logic [DWID-1:0]   data_q;
    logic [SW-1:0]     strb_q;
    logic              awvalid_q, wvalid_q, arvalid_q;
    logic              rsp_valid_q, rsp_is_read_q, rsp_err_q, err_q;
    logic [TWID-1:0]   rsp_tag_q;
    logic [DWID-1:0]   rsp_data_q;
    logic [4:0]        free_cnt;
    // Storage covers the full 4-bit ID space so any bid/rid indexes it safely
    logic [TWID-1:0]   tag_mem [16];
    logic [15:0]       rd_mem, busy16;
    logic              can_acc, wr_grant, rd_grant, slot_free, b_hs, r_hs, rsp_hit, rsp_miss;

    always_comb begin
        alloc_id = '0;
        for (int i = MAXOUT - 1; i >= 0; i--)
            if (free[i]) alloc_id = 4'(i);
    end

    assign can_acc  = (state == IDLE) && (|free);
    assign wr_grant = can_acc && bus.wr_req_valid && (!bus.rd_req_valid || !rr_rd);
    assign rd_grant = can_acc && bus.rd_req_valid && (!bus.wr_req_valid || rr_rd);
    assign bus.wr_req_ready = wr_grant;
    assign bus.rd_req_ready = rd_grant;

    // B wins over R whenever both are presented
    assign slot_free  = !rsp_valid_q || bus.rsp_ready;
    assign bus.bready = slot_free;
    assign bus.rready = slot_free && !bus.bvalid;
    assign b_hs       = bus.bvalid && slot_free;
    assign r_hs       = bus.rvalid && slot_free && !bus.bvalid;
    assign rsp_id     = b_hs ? bus.bid : bus.rid;

    always_comb begin
        busy16 = '0;
        busy16[MAXOUT-1:0] = ~free;
    end

    assign rsp_hit  = (b_hs || r_hs) && busy16[rsp_id];
    assign rsp_miss = (b_hs || r_hs) && !busy16[rsp_id];

    always_comb begin
        free_nxt = free;
        for (int i = 0; i < MAXOUT; i++) begin
            if ((wr_grant || rd_grant) && alloc_id == 4'(i)) free_nxt[i] = 1'b0;
            if (rsp_hit && rsp_id == 4'(i))                  free_nxt[i] = 1'b1;
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < MAXOUT; i++) free_cnt = free_cnt + 5'(free[i]);
    end
    assign bus.outstanding = 5'(MAXOUT) - free_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            free          <= '1;
            rr_rd         <= 1'b1;
            id_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            strb_q        <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            free <= free_nxt;
            case (state)
                IDLE: begin
                    // rr points at the queue that did not win this grant
                    if (wr_grant) begin
                        addr_q    <= bus.wr_req_addr;
                        data_q    <= bus.wr_req_data;
                        strb_q    <= bus.wr_req_strb;
                        id_q      <= alloc_id;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        rr_rd     <= 1'b1;
                        state     <= WR;
                    end else if (rd_grant) begin
                        addr_q    <= bus.rd_req_addr;
                        id_q      <= alloc_id;
                        arvalid_q <= 1'b1;
                        rr_rd     <= 1'b0;
                        state     <= RD;
                    end
                end
                WR: begin
                    if (awvalid_q && bus.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && bus.wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || bus.awready) && (!wvalid_q || bus.wready)) state <= IDLE;
                end
                RD: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (rsp_hit) begin
                rsp_valid_q   <= 1'b1;
                rsp_tag_q     <= tag_mem[rsp_id];
                rsp_is_read_q <= rd_mem[rsp_id];
                rsp_data_q    <= b_hs ? '0 : bus.rdata;
                rsp_err_q     <= b_hs ? (bus.bresp != 2'b00)
                                      : ((bus.rresp != 2'b00) || !bus.rlast);
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            if (rsp_miss) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_grant || rd_grant) begin
            tag_mem[alloc_id] <= wr_grant ? bus.wr_req_tag : bus.rd_req_tag;
            rd_mem[alloc_id]  <= rd_grant;
        end
    end

    assign bus.awid    = id_q;
    assign bus.arid    = id_q;
    assign bus.awaddr  = addr_q;
    assign bus.araddr  = addr_q;
    assign bus.awlen   = 8'd0;
    assign bus.arlen   = 8'd0;
    assign bus.awsize  = 3'($clog2(SW));
    assign bus.arsize  = 3'($clog2(SW));
    assign bus.awburst = 2'b01;
    assign bus.arburst = 2'b01;
    assign bus.awvalid = awvalid_q;
    assign bus.arvalid = arvalid_q;
    assign bus.wdata   = data_q;
    assign bus.wstrb   = strb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;

    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_is_read    = rsp_is_read_q;
    assign bus.rsp_tag        = rsp_tag_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.err_unexpected = err_q;
endmodule

// File: doc/rou_axi_req_sched.md
Name: rou_axi_req_sched

Overview:
- Issues single-beat AXI4 transactions for the ring AXI master.
- Decoded ring read and write requests arrive on two valid/ready queues.
- A round-robin arbiter shares one issue engine and a pool of AXI IDs between the two queues.
- B/R responses are matched back to the originating ring tag and returned on one response stream, which the ring NIF turns into reply messages.

Parameters:
DWID, 128, AXI data width in bits; one of 32/64/128/256/512.
AWID, 32, address width.
TWID, 5, ring transaction tag width.
MAXOUT, 4, maximum outstanding AXI transactions (1..16); equals the ID pool size.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_req_valid  in  1  write request valid
wr_req_ready  out  1  write request accepted
wr_req_addr  in  AWID  write address
wr_req_data  in  DWID  write data
wr_req_strb  in  DWID/8  write byte enables
wr_req_tag  in  TWID  ring tag
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read request accepted
rd_req_addr  in  AWID  read address
rd_req_tag  in  TWID  ring tag
awid/arid  out  4  AXI ID
awaddr/araddr  out  AWID  address
awlen/arlen  out  8  constant 0
awsize/arsize  out  3  constant log2(DWID/8)
awburst/arburst  out  2  constant 2'b01 (INCR)
awvalid/arvalid  out  1; awready/arready  in  1  address handshakes
wdata  out  DWID; wstrb  out  DWID/8; wlast  out  1 (constant 1); wvalid  out  1; wready  in  1
bid  in  4; bresp  in  2; bvalid  in  1; bready  out  1
rid  in  4; rdata  in  DWID; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1
rsp_valid  out  1; rsp_ready  in  1  response stream handshake
rsp_is_read  out  1; rsp_tag  out  TWID; rsp_data  out  DWID; rsp_err  out  1
outstanding  out  5  count of allocated IDs
err_unexpected  out  1  sticky flag: response received with an unallocated ID

Behaviour:

ID pool:
- free bitmap [MAXOUT-1:0]; per-ID storage of tag and is_read.
- Allocation takes the lowest free ID.
- An ID freed in cycle N is usable for allocation from cycle N+1.
- Alloc and free in the same cycle are both applied.
- outstanding = MAXOUT minus popcount(free).

Arbiter and issue FSM, states IDLE, WR, RD:
- A request may be accepted only when state==IDLE and at least one ID is free.
- If both queues are valid, grant the queue not granted last (rr pointer). Otherwise grant whichever queue is valid.
- wr_req_ready and rd_req_ready are combinational from state, free, the valids and rr. At most one is high per cycle.
- On accept:
  - Latch address, data, strobe, tag and the allocated ID into output registers.
  - Toggle rr.
  - Go to WR (awvalid=wvalid=1) or RD (arvalid=1) on the next cycle.
- WR: awvalid drops after the aw handshake and wvalid drops after the w handshake, independently. W may complete before or after AW. Return to IDLE in the cycle after both are done.
- RD: hold arvalid until arready, then return to IDLE.
- Request-to-valid latency is 1 cycle. The payload is stable while a valid is high.

Response path:
- One response register. Slot is free when !rsp_valid || rsp_ready.
- bready = slot free.
- rready = slot free && !bvalid, so B has priority over R.
- On a B or R handshake:
  - Load rsp_tag and rsp_is_read from the stored entry for bid/rid.
  - rsp_data = rdata for reads, 0 for writes.
  - rsp_err = (resp != 2'b00), or for reads (rlast==0).
  - Set rsp_valid and free the ID.
- If the ID is not allocated: accept and drop the beat, set err_unexpected (cleared only by rst), and leave rsp_valid unchanged.
- rsp_valid stays high until rsp_ready; the payload is stable while it is high.

Reset (rst high at a clock edge):
- state=IDLE; all IDs free; rr favours read first.
- All AXI valids=0, rsp_valid=0, err_unexpected=0, outstanding=0; bready/rready then follow the slot-free rule.
- Output payload registers are 0.
- Reset mid-transaction abandons it; there is no AXI recovery.

Full: when outstanding==MAXOUT, both req_ready stay low until a response frees an ID.

Test Plan:
- Single write: addr=0x100, data=0xA5..., strb=0xFFFF, tag=3; awready/wready high -> aw/w valid in the cycle after accept, awid=0; bid=0/bresp=0 -> rsp_valid, rsp_tag=3, rsp_is_read=0, rsp_err=0, outstanding back to 0.
- W before AW: wready=1, awready held low 5 cycles -> wvalid drops after 1 cycle, awvalid held 6 cycles, state returns to IDLE after the AW handshake.
- Both queues continuously valid with 5 reads and 5 writes -> grants alternate R,W,R,W,...; IDs 0..3 allocated; 5th request stalls until the first response frees an ID.
- B and R valid in the same cycle with rsp_ready=1 -> B delivered first, R next cycle; rresp=2'b10 -> rsp_err=1 with rdata passed through.
- rsp_ready low 4 cycles with a response pending -> bready/rready low, rsp payload stable; bid=7 when unallocated -> err_unexpected=1 and no rsp_valid.
- rst asserted mid-WR with awvalid high -> next cycle awvalid=0, outstanding=0, wr_req_ready=1 if wr_req_valid.
